// File: rtl/frog_game_ctrl.sv
// Frame-rate sequencer for the frog/obstacle game: button debounce, collision latch,
// lives/score bookkeeping and the IDLE/PLAY/HIT/WIN/OVER state machine.
module frog_game_ctrl #(
    parameter int LIVES           = 3,
    parameter int TOP_LANE        = 7,
    parameter int LANE_PITCH      = 40,
    parameter int BASE_Y          = 440,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int HIT_FRAMES      = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_animate,
    input  logic        i_up_btn,
    input  logic        i_down_btn,
    input  logic        i_collide,
    output logic [2:0]  o_state,
    output logic [3:0]  o_lane,
    output logic [11:0] o_frog_y,
    output logic [1:0]  o_lives,
    output logic [7:0]  o_score,
    output logic        o_frog_visible,
    output logic        o_freeze
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PLAY = 3'd1;
    localparam logic [2:0] ST_HIT  = 3'd2;
    localparam logic [2:0] ST_WIN  = 3'd3;
    localparam logic [2:0] ST_OVER = 3'd4;

    localparam logic [7:0] HIT_INIT = 8'(HIT_FRAMES);

    logic [1:0] btn_raw;
    logic [1:0] btn_event;
    logic       up_ev;
    logic       dn_ev;

    assign btn_raw = {i_down_btn, i_up_btn};

    // Index 0 = up, 1 = down. Event fires once on the frame the count reaches the threshold.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic       meta_reg;
            logic       sync_reg;
            logic [3:0] cnt_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    cnt_reg  <= 4'd0;
                end else begin
                    meta_reg <= btn_raw[gi];
                    sync_reg <= meta_reg;
                    if (i_animate) begin
                        if (!sync_reg)
                            cnt_reg <= 4'd0;
                        else if (cnt_reg != 4'(DEBOUNCE_FRAMES))
                            cnt_reg <= cnt_reg + 4'd1;
                    end
                end
            end

            assign btn_event[gi] = i_animate & sync_reg & (cnt_reg == 4'(DEBOUNCE_FRAMES - 1));
        end
    endgenerate

    assign up_ev = btn_event[0];
    assign dn_ev = btn_event[1];

    logic collide_reg;
    logic frame_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            collide_reg <= 1'b0;
        else if (i_animate)
            collide_reg <= 1'b0;
        else if (i_collide)
            collide_reg <= 1'b1;
    end

    assign frame_hit = collide_reg | i_collide;

    logic [2:0] state_reg,   state_next;
    logic [3:0] lane_reg,    lane_next;
    logic [1:0] lives_reg,   lives_next;
    logic [7:0] score_reg,   score_next;
    logic [7:0] timer_reg,   timer_next;
    logic       visible_reg, visible_next;
    logic       freeze_reg,  freeze_next;
    logic [7:0] timer_dec;
    logic [3:0] lane_inc;

    assign timer_dec = timer_reg - 8'd1;
    assign lane_inc  = lane_reg + 4'd1;

    always_comb begin
        state_next   = state_reg;
        lane_next    = lane_reg;
        lives_next   = lives_reg;
        score_next   = score_reg;
        timer_next   = timer_reg;
        visible_next = visible_reg;
        if (i_animate) begin
            case (state_reg)
                ST_IDLE: begin
                    if (up_ev || dn_ev)
                        state_next = ST_PLAY;
                end
                ST_PLAY: begin
                    if (frame_hit) begin
                        state_next   = ST_HIT;
                        lives_next   = (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
                        timer_next   = HIT_INIT;
                        visible_next = ~HIT_INIT[3];
                    end else if (up_ev && dn_ev) begin
                        lane_next = lane_reg;
                    end else if (up_ev) begin
                        lane_next = lane_inc;
                        if (lane_inc == 4'(TOP_LANE)) begin
                            state_next = ST_WIN;
                            score_next = (score_reg != 8'hFF) ? score_reg + 8'd1 : score_reg;
                            timer_next = HIT_INIT;
                        end
                    end else if (dn_ev && lane_reg != 4'd0) begin
                        lane_next = lane_reg - 4'd1;
                    end
                end
                ST_HIT: begin
                    timer_next   = timer_dec;
                    visible_next = ~timer_dec[3];
                    if (timer_dec == 8'd0) begin
                        visible_next = 1'b1;
                        if (lives_reg == 2'd0) begin
                            state_next = ST_OVER;
                        end else begin
                            state_next = ST_PLAY;
                            lane_next  = 4'd0;
                        end
                    end
                end
                ST_WIN: begin
                    timer_next = timer_dec;
                    if (timer_dec == 8'd0) begin
                        state_next = ST_PLAY;
                        lane_next  = 4'd0;
                    end
                end
                ST_OVER: begin
                    if (up_ev || dn_ev) begin
                        state_next = ST_IDLE;
                        lives_next = 2'(LIVES);
                        score_next = 8'd0;
                        lane_next  = 4'd0;
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    lane_next    = 4'd0;
                    visible_next = 1'b1;
                end
            endcase
        end
        freeze_next = (state_next == ST_HIT) || (state_next == ST_WIN) || (state_next == ST_OVER);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            lane_reg    <= 4'd0;
            lives_reg   <= 2'(LIVES);
            score_reg   <= 8'd0;
            timer_reg   <= 8'd0;
            visible_reg <= 1'b1;
            freeze_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lane_reg    <= lane_next;
            lives_reg   <= lives_next;
            score_reg   <= score_next;
            timer_reg   <= timer_next;
            visible_reg <= visible_next;
            freeze_reg  <= freeze_next;
        end
    end

    assign o_state        = state_reg;
    assign o_lane         = lane_reg;
    assign o_frog_y       = 12'(BASE_Y) - 12'(32'(lane_reg) * LANE_PITCH);
    assign o_lives        = lives_reg;
    assign o_score        = score_reg;
    assign o_frog_visible = visible_reg;
    assign o_freeze       = freeze_reg;

endmodule
